fxp8s_mat_streamer: RTL
=======================

# fxp8s_mat_streamer

Upstream feeder for `fxp8s_pe_array`. It accepts 32-bit host words carrying one matrix, either A or B, each up to 3x3 elements of fxp8s. It unpacks the words into the array's byte-wide input stream and drives the framing strobes (`in_mat`, `in_new_row`, `in_mat_done`) so the array zero-pads short rows and short matrices. One matrix is streamed per header; the host sends A and B as two consecutive packets.

## Interface
Parameters:
- `HDR_MAT_BIT`, 31: header bit selecting the matrix (0 = A, 1 = B).
- `HDR_ROWS_LSB`, 0: LSB of the 2-bit row count field.
- `HDR_COLS_LSB`, 4: LSB of the 2-bit column count field.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  host word valid.
- `s_ready`  out  1  block accepts the host word this cycle.
- `s_data`  in  32  header or payload word.
- `en_in_data`  out  1  beat valid toward the PE array.
- `rdy_in_data`  in  1  PE array accepts a data beat.
- `in_mat`  out  1  matrix select, constant for the whole packet.
- `in_new_row`  out  1  row-pad beat.
- `in_mat_done`  out  1  matrix-pad beat.
- `in_data`  out  8  fxp8s element. Driven to 0 on pad beats.
- `busy`  out  1  a packet is in flight (any state except IDLE).
- `err_hdr`  out  1  one-cycle pulse when a header is dropped.

## Operation
- **Packet format.** A packet is one header word followed by ceil(R·C/4) payload words. R is the rows field and C is the columns field, each in 1..3. Elements are row-major and little-endian within a word: element k sits in byte k mod 4. Unused bytes of the final word are discarded.
- **Header checks.** If R = 0 or C = 0, the header is dropped. `err_hdr` pulses, and the state stays IDLE.
- **States:**
  - IDLE: `s_ready`=1. A header handshake latches `in_mat`, R and C, clears the row/column counters, and moves to LOAD.
  - LOAD: `s_ready`=1. A word handshake fills a 32-bit buffer, sets the byte index to 0, and moves to EMIT.
  - EMIT: `en_in_data`=1 with the current byte. A transfer happens when `en_in_data & rdy_in_data`, and then:
    - the column counter advances;
    - at column C-1, the row counter advances and the column clears;
    - if C<3, go to ROWPAD;
    - else if the last real element was sent, go to MATPAD when R<3, or IDLE when R=3;
    - else if the byte index is 3, go to LOAD;
    - else increment the byte index.
  - ROWPAD: `en_in_data`=1, `in_new_row`=1, `in_data`=0 for exactly 3-C cycles, regardless of `rdy_in_data`. Pad beats are never back-pressured. Exit to:
    - MATPAD (R<3) or IDLE (R=3) after the last row;
    - LOAD if the buffer is exhausted;
    - otherwise EMIT.
  - MATPAD: `en_in_data`=1, `in_mat_done`=1, `in_data`=0 for exactly 3·(3-R) cycles, then IDLE.
- **Strobe exclusivity.** `in_new_row` and `in_mat_done` are never high together, and never high during EMIT.
- **Element totals.** Every packet produces exactly 9 element slots toward the array: R·C data beats plus the pads.
- **No arithmetic.** Bytes pass through unmodified. The counters are 2-bit, the pad counter is 3-bit, and none of them wraps inside a packet.
- **Reset mid-packet.** Asserting `rst` mid-packet aborts the packet. Remaining host words are treated as headers after reset; recovery is the host's responsibility.

## Timing
- **Reset values.** Every output is 0 during and after reset except `s_ready`, which is 1 once IDLE is entered after reset deassertion.
- **Latency.** Header accepted at cycle t; earliest first payload accept at t+1; earliest first beat at t+2.
- **Word refill bubble.** `s_ready` is 0 during EMIT, ROWPAD and MATPAD. This gives one bubble cycle per word refill, which is accepted.
- **Stall behaviour.** In EMIT with `rdy_in_data`=0, `in_data`, `in_mat` and the flags hold stable.
- **Strobe timing.** `err_hdr` is registered and asserts the cycle after the bad header handshake.
- **Pad length.** Pad runs last exactly the stated counts with no gaps.

## Structure
- **Shared package `fxp8s_pkg`:**
  - FXP8S width, sign and magnitude ranges;
  - header field positions;
  - state enum (IDLE, LOAD, EMIT, ROWPAD, MATPAD);
  - the constant 3 as the array dimension.
- **Datapath.** Single module, roughly 200 lines.
- **Optional sub-module.** `fxp8s_word_unpacker`, a 32-bit buffer with a byte-select index, is natural but optional.

## Test plan
- **Full 3x3 A.** Header 0x00000033, then words 0x04030201, 0x08070605, 0x00000009 → nine beats 01..09 with `in_mat`=0, no pad strobes, back to IDLE.
- **2x2 B.** Header 0x80000022, then 0x44332211 → beats:
  - 11, 22;
  - one `in_new_row` beat with data 0;
  - 33, 44;
  - one `in_new_row` beat;
  - three `in_mat_done` beats;
  - `in_mat`=1 throughout.
- **1x3 A with back-pressure.** Header 0x00000031, word 0x00302010, `rdy_in_data` low for 2 cycles before each beat → 10, 20, 30 each held stable, then six `in_mat_done` beats unaffected by `rdy_in_data`.
- **Bad header.** Header 0x00000030 (R=0) → `err_hdr` one-cycle pulse, no beats, `busy`=0, next valid header accepted normally.
- **Reset mid-packet.** Assert `rst` after the second beat of a 3x3 packet → all outputs 0 immediately, `s_ready`=1 after release, a fresh 2x2 packet streams correctly.

Source files
------------

// File: rtl/fxp8s_pkg.sv
// fxp8s_pkg: shared fxp8s format, header layout and streamer state definitions.
package fxp8s_pkg;
    localparam int FXP8S_W        = 8;
    localparam int FXP8S_SIGN_BIT = FXP8S_W - 1;
    localparam int FXP8S_MIN      = -(1 << FXP8S_SIGN_BIT);
    localparam int FXP8S_MAX      = (1 << FXP8S_SIGN_BIT) - 1;
    localparam int HDR_MAT_POS    = 31;
    localparam int HDR_ROWS_POS   = 0;
    localparam int HDR_COLS_POS   = 4;
    localparam logic [1:0] DIM    = 2'd3;
    typedef enum logic [2:0] {IDLE, LOAD, EMIT, ROWPAD, MATPAD} state_t;
    // matrix-pad beats needed to fill the remaining rows of a 3x3 frame
    function automatic logic [2:0] mat_pad_len(input logic [1:0] rows);
        return (rows == 2'd1) ? 3'd6 : (rows == 2'd2) ? 3'd3 : 3'd0;
    endfunction
endpackage

// File: rtl/fxp8s_word_unpacker.sv
// fxp8s_word_unpacker: 32-bit word buffer presenting one little-endian byte at a time.
module fxp8s_word_unpacker
    import fxp8s_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               adv,
    input  logic [31:0]        word,
    output logic [FXP8S_W-1:0] data,
    output logic               last
);
    logic [31:0] word_q;
    logic [1:0]  idx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx    <= '0;
        end else if (load) begin
            word_q <= word;
            idx    <= '0;
        end else if (adv) begin
            idx    <= idx + 2'd1;
        end
    end
    assign data = word_q[idx*FXP8S_W +: FXP8S_W];
    assign last = idx == 2'd3;
endmodule

// File: rtl/fxp8s_mat_streamer.sv
// fxp8s_mat_streamer: unpacks host matrix packets into the framed byte stream
// of fxp8s_pe_array, inserting row and matrix pad beats up to a 3x3 frame.
module fxp8s_mat_streamer
    import fxp8s_pkg::*;
#(
    parameter int HDR_MAT_BIT  = HDR_MAT_POS,
    parameter int HDR_ROWS_LSB = HDR_ROWS_POS,
    parameter int HDR_COLS_LSB = HDR_COLS_POS
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [31:0]        s_data,
    output logic               en_in_data,
    input  logic               rdy_in_data,
    output logic               in_mat,
    output logic               in_new_row,
    output logic               in_mat_done,
    output logic [FXP8S_W-1:0] in_data,
    output logic               busy,
    output logic               err_hdr
);
    state_t             state, state_n;
    logic [1:0]         r_q, c_q, row, col, r_n, c_n, row_n, col_n;
    logic [2:0]         pad, pad_n;
    logic               refill, refill_n, mat_n, err_n, load, adv, ulast;
    logic [FXP8S_W-1:0] ubyte;
    logic [1:0]         hdr_rows, hdr_cols;
    logic               last_col, last_row;

    assign hdr_rows = s_data[HDR_ROWS_LSB +: 2];
    assign hdr_cols = s_data[HDR_COLS_LSB +: 2];
    assign last_col = col == c_q - 2'd1;
    assign last_row = row == r_q - 2'd1;
    assign adv      = (state == EMIT) & rdy_in_data;

    fxp8s_word_unpacker u_unpack (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .adv  (adv),
        .word (s_data),
        .data (ubyte),
        .last (ulast)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            in_mat  <= 1'b0;
            r_q     <= '0;
            c_q     <= '0;
            row     <= '0;
            col     <= '0;
            pad     <= '0;
            refill  <= 1'b0;
            err_hdr <= 1'b0;
        end else begin
            state   <= state_n;
            in_mat  <= mat_n;
            r_q     <= r_n;
            c_q     <= c_n;
            row     <= row_n;
            col     <= col_n;
            pad     <= pad_n;
            refill  <= refill_n;
            err_hdr <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        mat_n    = in_mat;
        r_n      = r_q;
        c_n      = c_q;
        row_n    = row;
        col_n    = col;
        pad_n    = pad;
        refill_n = refill;
        err_n    = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: if (s_valid) begin
                if (hdr_rows == 2'd0 || hdr_cols == 2'd0) err_n = 1'b1;
                else begin
                    mat_n   = s_data[HDR_MAT_BIT];
                    r_n     = hdr_rows;
                    c_n     = hdr_cols;
                    row_n   = '0;
                    col_n   = '0;
                    state_n = LOAD;
                end
            end
            LOAD: if (s_valid) begin
                load    = 1'b1;
                state_n = EMIT;
            end
            EMIT: if (rdy_in_data) begin
                col_n    = last_col ? 2'd0 : col + 2'd1;
                row_n    = last_col ? row + 2'd1 : row;
                refill_n = ulast;
                // short rows always pad, even after the final element
                if (last_col && c_q != DIM) begin
                    state_n = ROWPAD;
                    pad_n   = {1'b0, DIM} - {1'b0, c_q};
                end else if (last_col && last_row) begin
                    state_n = (r_q == DIM) ? IDLE : MATPAD;
                    pad_n   = mat_pad_len(r_q);
                end else if (ulast) state_n = LOAD;
            end
            ROWPAD: begin
                pad_n = pad - 3'd1;
                if (pad == 3'd1) begin
                    if (row == r_q) begin
                        state_n = (r_q == DIM) ? IDLE : MATPAD;
                        pad_n   = mat_pad_len(r_q);
                    end else state_n = refill ? LOAD : EMIT;
                end
            end
            MATPAD: begin
                pad_n = pad - 3'd1;
                if (pad == 3'd1) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign s_ready     = ~rst & (state == IDLE || state == LOAD);
    assign en_in_data  = state == EMIT || state == ROWPAD || state == MATPAD;
    assign in_new_row  = state == ROWPAD;
    assign in_mat_done = state == MATPAD;
    assign in_data     = (state == EMIT) ? ubyte : '0;
    assign busy        = state != IDLE;
endmodule
